// File: rtl/countdown_display_pkg.sv
// Shared display constants: active-low {g..a} segment patterns and digit-index width.
package countdown_display_pkg;

   localparam int DIGIT_IDX_W = 2;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] AN_OFF    = 4'b1111;

   function automatic logic [6:0] seg_encode(input logic [3:0] digit);
      logic [6:0] pattern;
      case (digit)
         4'd0:    pattern = SEG_0;
         4'd1:    pattern = SEG_1;
         4'd2:    pattern = SEG_2;
         4'd3:    pattern = SEG_3;
         4'd4:    pattern = SEG_4;
         4'd5:    pattern = SEG_5;
         4'd6:    pattern = SEG_6;
         4'd7:    pattern = SEG_7;
         4'd8:    pattern = SEG_8;
         4'd9:    pattern = SEG_9;
         default: pattern = SEG_BLANK;
      endcase
      return pattern;
   endfunction

endpackage

// File: rtl/countdown_display_if.sv
// Countdown-to-display link: remaining seconds plus the expired (pause) flag.
interface countdown_display_if;

   logic [4:0] time_value;
   logic       expired;

   modport master (output time_value, output expired);
   modport slave  (input  time_value, input  expired);

endinterface

// File: rtl/countdown_display_bin5_to_bcd.sv
// Combinational split of a 0..31 value into a tens digit (0..3) and a ones digit (0..9).
module bin5_to_bcd (
   input  logic [4:0] bin,
   output logic [1:0] tens,
   output logic [3:0] ones
);

   logic [3:0] tens_x10_mod16;

   always_comb begin
      tens = 2'd0;
      if (bin >= 5'd30) begin
         tens = 2'd3;
      end else if (bin >= 5'd20) begin
         tens = 2'd2;
      end else if (bin >= 5'd10) begin
         tens = 2'd1;
      end
   end

   // The true remainder is always 0..9, so subtracting tens*10 modulo 16 from the low nibble is exact.
   always_comb begin
      case (tens)
         2'd0:    tens_x10_mod16 = 4'd0;
         2'd1:    tens_x10_mod16 = 4'd10;
         2'd2:    tens_x10_mod16 = 4'd4;
         default: tens_x10_mod16 = 4'd14;
      endcase
      ones = bin[3:0] - tens_x10_mod16;
   end

endmodule

// File: rtl/countdown_display.sv
// Four-digit multiplexed seven-segment driver for the round countdown, with a
// per-frame value snapshot and blinking while the countdown is expired.
module countdown_display
   import countdown_display_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 25000000,
   parameter bit LZ_BLANK    = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   countdown_display_if.slave        cd,
   output logic [3:0]                an,
   output logic [6:0]                seg,
   output logic                      dp
);

   localparam int SCAN_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [SCAN_W-1:0]      scan_cnt_q,  scan_cnt_d;
   logic [DIGIT_IDX_W-1:0] digit_idx_q, digit_idx_d;
   logic [4:0]             shadow_q,    shadow_d;
   logic                   expired_q,   expired_d;
   logic [BLINK_W-1:0]     blink_cnt_q, blink_cnt_d;
   logic                   blink_off_q, blink_off_d;
   logic [3:0]             an_q,        an_d;
   logic [6:0]             seg_q,       seg_d;

   logic                   scan_tc;
   logic                   frame_end;
   logic                   blink_tc;
   logic [1:0]             tens;
   logic [3:0]             ones;

   bin5_to_bcd u_bcd (
      .bin  (shadow_q),
      .tens (tens),
      .ones (ones)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt_q  <= '0;
         digit_idx_q <= '0;
         shadow_q    <= '0;
         expired_q   <= 1'b0;
         blink_cnt_q <= '0;
         blink_off_q <= 1'b0;
         an_q        <= AN_OFF;
         seg_q       <= SEG_BLANK;
      end else begin
         scan_cnt_q  <= scan_cnt_d;
         digit_idx_q <= digit_idx_d;
         shadow_q    <= shadow_d;
         expired_q   <= expired_d;
         blink_cnt_q <= blink_cnt_d;
         blink_off_q <= blink_off_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
      end
   end

   // Both digits of a frame come from one sample taken as the scan wraps back to digit 0.
   always_comb begin
      scan_tc     = (scan_cnt_q == SCAN_W'(REFRESH_DIV - 1));
      scan_cnt_d  = scan_tc ? '0 : scan_cnt_q + 1'b1;
      digit_idx_d = scan_tc ? digit_idx_q + 1'b1 : digit_idx_q;
      frame_end   = scan_tc && (digit_idx_q == DIGIT_IDX_W'(3));
      shadow_d    = frame_end ? cd.time_value : shadow_q;
      expired_d   = frame_end ? cd.expired    : expired_q;
   end

   always_comb begin
      blink_tc    = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
      if (expired_q) begin
         blink_cnt_d = blink_tc ? '0 : blink_cnt_q + 1'b1;
         blink_off_d = blink_tc ? ~blink_off_q : blink_off_q;
      end
   end

   always_comb begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
      if (!blink_off_q) begin
         case (digit_idx_q)
            2'd0: begin
               an_d  = 4'b1110;
               seg_d = seg_encode(ones);
            end
            2'd1: begin
               if (!(LZ_BLANK && (tens == 2'd0))) begin
                  an_d  = 4'b1101;
                  seg_d = seg_encode({2'b00, tens});
               end
            end
            default: begin
               an_d  = AN_OFF;
               seg_d = SEG_BLANK;
            end
         endcase
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = 1'b1;

endmodule
